// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: table-driven LED sequencer feeding the I/T pins of a tri-state buffer.
// Define LEDSEQ_PWM_DIM_EN to render DIM as a driven 1-in-8 low pulse instead of high-Z.
module led_seq_ctrl #(
  parameter int unsigned TICK_DIV = 2500000,
  parameter int unsigned STEPS    = 4,
  parameter int unsigned DUR_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             loop,
  input  logic             cfg_we,
  input  logic [3:0]       cfg_addr,
  input  logic [1:0]       cfg_mode,
  input  logic [DUR_W-1:0] cfg_dur,
  output logic             busy,
  output logic             done,
  output logic [3:0]       step_idx,
  output logic             led_o,
  output logic             led_oe
);
  localparam int unsigned   PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [3:0]    LAST_IDX  = 4'(STEPS - 1);

  typedef enum logic [1:0] {M_OFF, M_DIM, M_BRIGHT, M_END} mode_t;
  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           state;
  mode_t            cur_mode;
  mode_t            tbl_mode [STEPS];
  logic [DUR_W-1:0] tbl_dur  [STEPS];
  logic [DUR_W-1:0] rem;
  logic [PW-1:0]    presc;
  logic [3:0]       next_idx;
  mode_t            next_mode;
  logic [DUR_W-1:0] next_dur;
  logic             seq_last;

`ifdef LEDSEQ_PWM_DIM_EN
  logic [2:0] pwm_cnt;
  logic       pwm_lo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_cnt <= '0;
    else        pwm_cnt <= pwm_cnt + 3'd1;
  end

  // led_o is registered, so look one count ahead to land low while pwm_cnt == 0
  assign pwm_lo = (pwm_cnt == 3'd7);
`endif

  // Returns {led_o, led_oe}
  function automatic logic [1:0] drive(input mode_t m);
    case (m)
      M_BRIGHT: drive = 2'b01;
`ifdef LEDSEQ_PWM_DIM_EN
      M_DIM:    drive = {~pwm_lo, 1'b1};
`else
      M_DIM:    drive = 2'b10;
`endif
      default:  drive = 2'b11;
    endcase
  endfunction

  assign next_idx = step_idx + 4'd1;

  always_comb begin
    next_mode = M_END;
    next_dur  = '0;
    for (int unsigned i = 0; i < STEPS; i++) begin
      if (next_idx == 4'(i)) begin
        next_mode = tbl_mode[i];
        next_dur  = tbl_dur[i];
      end
    end
  end

  assign seq_last = (step_idx == LAST_IDX) || (next_mode == M_END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cur_mode <= M_OFF;
      busy     <= 1'b0;
      done     <= 1'b0;
      step_idx <= '0;
      led_o    <= 1'b1;
      led_oe   <= 1'b1;
      presc    <= '0;
      rem      <= '0;
      for (int unsigned i = 0; i < STEPS; i++) begin
        tbl_mode[i] <= (i == 0) ? M_OFF : (i == 1) ? M_DIM : (i == 2) ? M_BRIGHT : M_END;
        tbl_dur[i]  <= (i < 3) ? DUR_W'(5) : '0;
      end
    end else begin
      done <= 1'b0;
      // Loads below read the pre-write table, so a same-cycle edit applies on the next load
      if (cfg_we) begin
        for (int unsigned i = 0; i < STEPS; i++) begin
          if (cfg_addr == 4'(i)) begin
            tbl_mode[i] <= mode_t'(cfg_mode);
            tbl_dur[i]  <= cfg_dur;
          end
        end
      end
      unique case (state)
        S_IDLE: begin
          presc <= '0;
          if (start && !stop) begin
            if (tbl_mode[0] != M_END) begin
              state           <= S_RUN;
              busy            <= 1'b1;
              step_idx        <= '0;
              rem             <= tbl_dur[0];
              cur_mode        <= tbl_mode[0];
              {led_o, led_oe} <= drive(tbl_mode[0]);
            end else begin
              done <= 1'b1;
            end
          end
        end
        S_RUN: begin
          {led_o, led_oe} <= drive(cur_mode);
          if (stop) begin
            state           <= S_IDLE;
            busy            <= 1'b0;
            step_idx        <= '0;
            cur_mode        <= M_OFF;
            {led_o, led_oe} <= 2'b11;
          end else if (presc == TICK_LAST) begin
            presc <= '0;
            if (rem != '0) begin
              rem <= rem - 1'b1;
            end else if (seq_last) begin
              if (loop && tbl_mode[0] != M_END) begin
                step_idx        <= '0;
                rem             <= tbl_dur[0];
                cur_mode        <= tbl_mode[0];
                {led_o, led_oe} <= drive(tbl_mode[0]);
              end else begin
                state           <= S_IDLE;
                busy            <= 1'b0;
                done            <= 1'b1;
                step_idx        <= '0;
                cur_mode        <= M_OFF;
                {led_o, led_oe} <= 2'b11;
              end
            end else begin
              step_idx        <= next_idx;
              rem             <= next_dur;
              cur_mode        <= next_mode;
              {led_o, led_oe} <= drive(next_mode);
            end
          end else begin
            presc <= presc + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_led_seq_ctrl.sv
// tb_led_seq_ctrl: directed and random stimulus against a cycle-countdown reference model,
// with a per-cycle expected-output queue drained by an independent monitor.
module tb_led_seq_ctrl;
  localparam int TD = 4;
  localparam int NS = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0, stop = 1'b0, loop = 1'b0, cfg_we = 1'b0;
  logic [3:0]    cfg_addr = '0;
  logic [1:0]    cfg_mode = '0;
  logic [DW-1:0] cfg_dur = '0;
  logic          busy, done, led_o, led_oe;
  logic [3:0]    step_idx;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  led_seq_ctrl #(.TICK_DIV(TD), .STEPS(NS), .DUR_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop(loop),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_mode(cfg_mode), .cfg_dur(cfg_dur),
    .busy(busy), .done(done), .step_idx(step_idx), .led_o(led_o), .led_oe(led_oe)
  );

  // Reference model: modes 0 OFF, 1 DIM, 2 BRIGHT, 3 END; each step is a plain cycle countdown
  int         m_mode [NS];
  int         m_dur  [NS];
  bit         m_run, m_done;
  int         m_idx, m_left;
  logic [7:0] exp_q[$];

  function automatic logic [1:0] leds(input int md);
    if (md == 1)      return 2'b10;
    else if (md == 2) return 2'b01;
    else              return 2'b11;
  endfunction

  function logic [7:0] snap();
    return {m_run, m_done, 4'(m_idx), m_run ? leds(m_mode[m_idx]) : 2'b11};
  endfunction

  task m_reset();
    for (int i = 0; i < NS; i++) begin
      m_mode[i] = (i < 3) ? i : 3;
      m_dur[i]  = (i < 3) ? 5 : 0;
    end
    m_run = 0; m_done = 0; m_idx = 0; m_left = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_reset();
      if (clk) exp_q.push_back(snap());
    end else begin
      m_done = 0;
      if (m_run) begin
        if (stop) m_run = 0;
        else begin
          m_left--;
          if (m_left == 0) begin
            if (m_idx == NS - 1 || m_mode[m_idx + 1] == 3) begin
              if (loop && m_mode[0] != 3) begin
                m_idx = 0; m_left = (m_dur[0] + 1) * TD;
              end else begin
                m_run = 0; m_done = 1;
              end
            end else begin
              m_idx++; m_left = (m_dur[m_idx] + 1) * TD;
            end
          end
        end
      end else if (start && !stop) begin
        if (m_mode[0] != 3) begin
          m_run = 1; m_idx = 0; m_left = (m_dur[0] + 1) * TD;
        end else m_done = 1;
      end
      if (cfg_we && cfg_addr < NS) begin
        m_mode[int'(cfg_addr)] = int'(cfg_mode);
        m_dur[int'(cfg_addr)]  = int'(cfg_dur);
      end
      if (!m_run) m_idx = 0;
      exp_q.push_back(snap());
    end
  end

  always @(negedge clk) begin
    logic [7:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {busy, done, step_idx, led_o, led_oe};
      n_checks++;
      if (a !== e)  begin
        n_fail++;
        $display("FAIL outputs @%0t: got busy=%b done=%b step=%0d led_o=%b led_oe=%b, expected busy=%b done=%b step=%0d led_o=%b led_oe=%b",
                 $time, a[7], a[6], a[5:2], a[1], a[0], e[7], e[6], e[5:2], e[1], e[0]);
      end
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [1:0] m, input int d);
    cfg_we = 1'b1; cfg_addr = a; cfg_mode = m; cfg_dur = DW'(d);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Cycles from start to the done pulse, bounded so a stuck DUT still reaches the summary
  task automatic done_latency(input string name, input int exp);
    int k = 0;
    while (done !== 1'b1 && k < 200) begin tick(); k++; end
    check(name, k, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(2);

    pulse_start();
    done_latency("default_done_latency", 72);
    wait_cyc(3);

    loop = 1'b1;
    pulse_start();
    wait_cyc(80);
    pulse_stop();
    loop = 1'b0;
    wait_cyc(3);

    cfg_write(4'd0, 2'd3, 0);
    pulse_start();
    wait_cyc(3);
    cfg_write(4'd0, 2'd0, 5);

    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    wait_cyc(3);
    pulse_start();
    wait_cyc(30);
    check("step1_before_restart", int'(step_idx), 1);
    pulse_start();
    wait_cyc(50);

    pulse_start();
    wait_cyc(5);
    cfg_write(4'd1, 2'd1, 0);
    cfg_write(4'd5, 2'd2, 7);
    done_latency("short_step1_done_latency", 45);
    wait_cyc(3);

    pulse_start();
    wait_cyc(45);
    check("pre_reset_bright", int'({led_o, led_oe}), 1);
    rst_n = 1'b0;
    #1;
    check("async_reset_busy", int'(busy), 0);
    check("async_reset_leds", int'({led_o, led_oe}), 3);
    check("async_reset_step", int'(step_idx), 0);
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(2);
    pulse_start();
    done_latency("table_reloaded_done_latency", 72);
    wait_cyc(3);

    for (int c = 0; c < 500; c++) begin
      start    = ($urandom_range(0, 19) == 0);
      stop     = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 49) == 0) loop = ~loop;
      cfg_we   = ($urandom_range(0, 14) == 0);
      cfg_addr = 4'($urandom_range(0, 7));
      cfg_mode = 2'($urandom_range(0, 3));
      cfg_dur  = DW'($urandom_range(0, 3));
      tick();
    end
    start = 1'b0; cfg_we = 1'b0; stop = 1'b1;
    tick();
    stop = 1'b0; loop = 1'b0;
    wait_cyc(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/led_seq_ctrl.md
# led_seq_ctrl

Programmable sequencer for a single tri-stateable LED pin. It steps through a small table of (drive mode, duration) entries, timed by an internal tick prescaler, and drives the `I`/`T` inputs of the board's bidirectional buffer primitive. It replaces hard-coded per-design blink state machines: a host or top-level FSM programs the table, pulses `start`, and waits for `done`.

## Interface
- `TICK_DIV`, default 2500000: clock cycles per tick (100 ms at 25 MHz); legal range 1 to 2^25.
- `STEPS`, default 4: table depth; legal range 2 to 16.
- `DUR_W`, default 8: width of the per-step duration field.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle start request.
- `stop`  in  1  single-cycle abort request.
- `loop`  in  1  level input; 1 = wrap the sequence indefinitely.
- `cfg_we`  in  1  table write strobe.
- `cfg_addr`  in  4  table index.
- `cfg_mode`  in  2  mode code: 00 OFF, 01 DIM, 10 BRIGHT, 11 END.
- `cfg_dur`  in  DUR_W  step length minus one, in ticks.
- `busy`  out  1  sequence running.
- `done`  out  1  one-cycle pulse on natural completion.
- `step_idx`  out  4  index of the active step.
- `led_o`  out  1  to buffer `I`.
- `led_oe`  out  1  to buffer `T` through an inverter; 1 = pin driven.

## Operation
- Two-state FSM: IDLE and RUN. All outputs are registered.
- Reset values:
  - state IDLE; `busy`=0, `done`=0, `step_idx`=0.
  - `led_o`=1, `led_oe`=1 (LED off, active-low).
  - prescaler 0.
- Table reset contents:
  - entry 0: OFF, duration 5
  - entry 1: DIM, duration 5
  - entry 2: BRIGHT, duration 5
  - entries 3 and up: END, duration 0
- Mode decode:
  - OFF: `led_oe`=1, `led_o`=1.
  - BRIGHT: `led_oe`=1, `led_o`=0.
  - DIM: `led_oe`=0, `led_o`=1 (pin high-Z).
  - END: not a drive mode; terminates the sequence.
  - IDLE always drives as OFF.
- A step lasts `cfg_dur`+1 ticks.
- A tick fires when the prescaler equals `TICK_DIV`-1; the prescaler then wraps to 0.
- The prescaler runs only in RUN and clears on every start.
- On `start` in IDLE:
  - If entry 0 is not END: enter RUN at step 0 and load its duration.
  - If entry 0 is END: stay in IDLE and pulse `done` on the next cycle.
- Step advance happens at the tick where the remaining count is 0. The next index is `step_idx`+1.
  - If `step_idx`=`STEPS`-1 or the next entry is END: with `loop`=1 go to step 0; with `loop`=0 go to IDLE and pulse `done`.
  - Otherwise load the next entry.
- `stop` aborts to IDLE on the next edge; no `done` pulse.
- `start` while `busy` is ignored.
- `start` and `stop` in the same cycle: `stop` wins.
- `cfg_we` with `cfg_addr`≥`STEPS` is ignored.
- Writes are allowed during RUN. Each entry is read when it is loaded, so an edit to the active step takes effect on its next load.
- `loop` is sampled only at wrap points.

## Timing
- `start` sampled at edge N: `busy`=1, `step_idx`=0, and step-0 drive levels are all valid after edge N.
- The first tick occurs at edge N+`TICK_DIV`.
- Output drive changes coincide exactly with the tick edge that advances the step.
- On completion, at the final tick edge:
  - `busy` falls.
  - `done` is high for exactly one cycle.
  - Outputs return to OFF.
- `stop` at edge M: IDLE and OFF after edge M.
- Asserting `rst_n` low mid-sequence immediately forces all reset values, including table contents.

## Configuration
- `LEDSEQ_PWM_DIM_EN` defined:
  - DIM drives `led_oe`=1.
  - `led_o`=0 for 1 of every 8 clocks, from a free-running 3-bit counter that resets to 0; the pin is low while the counter equals 0.
- `LEDSEQ_PWM_DIM_EN` undefined: DIM is high-Z as specified above, and the counter is not instantiated.

## Test plan
Use `TICK_DIV`=4 throughout.
- Reset, reset-default table, `loop`=0, `start` at edge N:
  - OFF during N to N+23.
  - DIM (`led_oe`=0) during N+24 to N+47.
  - BRIGHT during N+48 to N+71.
  - `done` pulse after edge N+72, then `busy`=0.
- Same as above with `loop`=1: after BRIGHT, `step_idx` returns to 0 at N+72, no `done` pulse; `stop` then returns IDLE/OFF on the next edge.
- Write entry 0 = END, then `start`: `busy` stays 0, `done` pulses once on the next cycle.
- `start` and `stop` in the same cycle from IDLE: no transition. `start` during RUN at step 1: no effect on `step_idx` or timing.
- Write entry 1 duration 0 during step 0: step 1 lasts 4 cycles. Write to `cfg_addr`=5: table unchanged.
- Assert `rst_n` low during BRIGHT: asynchronously `led_o`=1, `led_oe`=1, `busy`=0, table reloads defaults. With `LEDSEQ_PWM_DIM_EN`, DIM shows `led_o` low 1 of every 8 cycles with `led_oe`=1.
